// File: rtl/winograd_ch_accum_if.sv
// Handshake bundle for winograd_ch_accum: input tile/kernel stream and 2x2 output tile stream.
interface winograd_ch_accum_if #(
  parameter int W     = 8,
  parameter int ACC_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [16*W-1:0]    data;
  logic [9*W-1:0]     filter;
  logic               out_valid;
  logic               out_ready;
  logic [4*ACC_W-1:0] Y;

  modport master (
    output in_valid, data, filter, out_ready,
    input  in_ready, out_valid, Y
  );

  modport slave (
    input  in_valid, data, filter, out_ready,
    output in_ready, out_valid, Y
  );
endinterface

// File: rtl/winograd_ch_accum.sv
// Winograd F(2x2,3x3) tile engine: transforms each channel's tile/kernel, multiplies
// element-wise and accumulates CH channels before the inverse transform to a 2x2 tile.
module winograd_ch_accum #(
  parameter int W     = 8,
  parameter int CH    = 4,
  parameter int ACC_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  winograd_ch_accum_if.slave  bus,
  output logic                busy
);

  localparam int UW    = W + 2;
  localparam int VW    = W + 5;
  localparam int PW    = 2 * W + 7;
  localparam int XW    = ACC_W + 4;
  localparam int CNT_W = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CH - 1);

  typedef enum logic [1:0] {ACCUM = 2'd0, DRAIN = 2'd1, OUT = 2'd2} state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     ch_cnt_reg;
  logic                 in_ready, out_valid, accept;

  logic signed [W-1:0]     d_e[16];
  logic signed [W-1:0]     g_e[9];
  logic signed [UW-1:0]    t_u[16];
  logic signed [UW-1:0]    u_next[16];
  logic signed [VW-1:0]    p_v[12];
  logic signed [VW-1:0]    v_next[16];
  logic signed [ACC_W-1:0] m_next[16];
  logic signed [XW-1:0]    r_x[8];
  logic signed [XW-1:0]    y_full[4];
  logic signed [ACC_W-1:0] y_next[4];

  logic signed [UW-1:0]    u_reg[16];
  logic signed [VW-1:0]    v_reg[16];
  logic signed [ACC_W-1:0] m_reg[16];
  logic signed [ACC_W-1:0] acc_reg[16];
  logic signed [ACC_W-1:0] y_reg[4];
  logic s1_valid_reg, s1_first_reg, s1_last_reg;
  logic s2_valid_reg, s2_first_reg, s2_last_reg;
  logic s3_last_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_unpack_d
      assign d_e[gi]    = bus.data[gi*W +: W];
      assign m_next[gi] = ACC_W'(PW'(u_reg[gi]) * PW'(v_reg[gi]));
    end
    for (gi = 0; gi < 9; gi++) begin : g_unpack_g
      assign g_e[gi] = bus.filter[gi*W +: W];
    end
    for (gi = 0; gi < 4; gi++) begin : g_pack_y
      assign bus.Y[gi*ACC_W +: ACC_W] = y_reg[gi];
      assign y_next[gi] = ACC_W'(y_full[gi] >>> 2);
    end
  endgenerate

  // U = B^T d B, then V' = G' g G'^T (G' = 2G keeps the kernel transform integer).
  always_comb begin
    t_u    = '{default: '0};
    u_next = '{default: '0};
    p_v    = '{default: '0};
    v_next = '{default: '0};
    for (int j = 0; j < 4; j++) begin
      t_u[j]      = UW'(d_e[j])     - UW'(d_e[8 + j]);
      t_u[4 + j]  = UW'(d_e[4 + j]) + UW'(d_e[8 + j]);
      t_u[8 + j]  = UW'(d_e[8 + j]) - UW'(d_e[4 + j]);
      t_u[12 + j] = UW'(d_e[4 + j]) - UW'(d_e[12 + j]);
    end
    for (int i = 0; i < 4; i++) begin
      u_next[4*i]     = t_u[4*i]     - t_u[4*i + 2];
      u_next[4*i + 1] = t_u[4*i + 1] + t_u[4*i + 2];
      u_next[4*i + 2] = t_u[4*i + 2] - t_u[4*i + 1];
      u_next[4*i + 3] = t_u[4*i + 1] - t_u[4*i + 3];
    end
    for (int j = 0; j < 3; j++) begin
      p_v[j]     = VW'(g_e[j]) + VW'(g_e[j]);
      p_v[3 + j] = VW'(g_e[j]) + VW'(g_e[3 + j]) + VW'(g_e[6 + j]);
      p_v[6 + j] = VW'(g_e[j]) - VW'(g_e[3 + j]) + VW'(g_e[6 + j]);
      p_v[9 + j] = VW'(g_e[6 + j]) + VW'(g_e[6 + j]);
    end
    for (int i = 0; i < 4; i++) begin
      v_next[4*i]     = p_v[3*i] + p_v[3*i];
      v_next[4*i + 1] = p_v[3*i] + p_v[3*i + 1] + p_v[3*i + 2];
      v_next[4*i + 2] = p_v[3*i] - p_v[3*i + 1] + p_v[3*i + 2];
      v_next[4*i + 3] = p_v[3*i + 2] + p_v[3*i + 2];
    end
  end

  // A^T Acc A; the result carries the 4x scale of V', removed by the shift above.
  always_comb begin
    r_x    = '{default: '0};
    y_full = '{default: '0};
    for (int j = 0; j < 4; j++) begin
      r_x[j]     = XW'(acc_reg[j]) + XW'(acc_reg[4 + j]) + XW'(acc_reg[8 + j]);
      r_x[4 + j] = XW'(acc_reg[4 + j]) - XW'(acc_reg[8 + j]) - XW'(acc_reg[12 + j]);
    end
    for (int i = 0; i < 2; i++) begin
      y_full[2*i]     = r_x[4*i] + r_x[4*i + 1] + r_x[4*i + 2];
      y_full[2*i + 1] = r_x[4*i + 1] - r_x[4*i + 2] - r_x[4*i + 3];
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ACCUM: begin
        in_ready = 1'b1;
        if (bus.in_valid && (ch_cnt_reg == LAST_CH)) state_next = DRAIN;
      end
      DRAIN: begin
        if (s3_last_reg) state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  assign accept        = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign busy          = (state_reg != ACCUM) || (ch_cnt_reg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ACCUM;
      ch_cnt_reg   <= '0;
      s1_valid_reg <= 1'b0;
      s1_first_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s2_valid_reg <= 1'b0;
      s2_first_reg <= 1'b0;
      s2_last_reg  <= 1'b0;
      s3_last_reg  <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        u_reg[k]   <= '0;
        v_reg[k]   <= '0;
        m_reg[k]   <= '0;
        acc_reg[k] <= '0;
      end
      for (int k = 0; k < 4; k++) y_reg[k] <= '0;
    end else begin
      state_reg    <= state_next;
      s1_valid_reg <= accept;
      s1_first_reg <= accept && (ch_cnt_reg == '0);
      s1_last_reg  <= accept && (ch_cnt_reg == LAST_CH);
      s2_valid_reg <= s1_valid_reg;
      s2_first_reg <= s1_first_reg;
      s2_last_reg  <= s1_last_reg;
      s3_last_reg  <= s2_valid_reg && s2_last_reg;
      if (accept) begin
        ch_cnt_reg <= (ch_cnt_reg == LAST_CH) ? '0 : ch_cnt_reg + CNT_W'(1);
      end
      // Stages move only when a token is present, so input gaps freeze the pipeline data.
      for (int k = 0; k < 16; k++) begin
        if (accept) begin
          u_reg[k] <= u_next[k];
          v_reg[k] <= v_next[k];
        end
        if (s1_valid_reg) m_reg[k] <= m_next[k];
        if (s2_valid_reg) acc_reg[k] <= s2_first_reg ? m_reg[k] : acc_reg[k] + m_reg[k];
      end
      if ((state_reg == DRAIN) && s3_last_reg) begin
        for (int k = 0; k < 4; k++) y_reg[k] <= y_next[k];
      end
    end
  end

endmodule

// File: tb/tb_winograd_ch_accum.sv
// Scoreboard bench for winograd_ch_accum: expected tiles come from a direct 3x3
// convolution summed over channels and are matched against each output transfer.
module tb_winograd_ch_accum;
  localparam int W     = 8;
  localparam int CH    = 4;
  localparam int ACC_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  winograd_ch_accum_if #(.W(W), .ACC_W(ACC_W)) bus ();

  winograd_ch_accum #(.W(W), .CH(CH), .ACC_W(ACC_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ch_m     = 0;
  int acc_m[4];
  logic [4*ACC_W-1:0] exp_q[$];
  int                 lat_q[$];
  logic [4*ACC_W-1:0] last_exp;
  logic [16*W-1:0]    ones_d, neg_d, ramp_d;
  logic [9*W-1:0]     ones_g, pos_g, delta_g;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Direct convolution of one channel, accumulated; a completed group lands in the scoreboard.
  function automatic void model_accept(input logic [16*W-1:0] d, input logic [9*W-1:0] g);
    int y[4];
    int dv, gv;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        y[2*i + j] = 0;
        for (int k = 0; k < 3; k++) begin
          for (int l = 0; l < 3; l++) begin
            dv = $signed(d[((i + k)*4 + j + l)*W +: W]);
            gv = $signed(g[(k*3 + l)*W +: W]);
            y[2*i + j] += dv * gv;
          end
        end
      end
    end
    for (int k = 0; k < 4; k++) acc_m[k] = (ch_m == 0) ? y[k] : acc_m[k] + y[k];
    if (ch_m == CH - 1) begin
      logic [4*ACC_W-1:0] e;
      for (int k = 0; k < 4; k++) e[k*ACC_W +: ACC_W] = acc_m[k];
      exp_q.push_back(e);
      lat_q.push_back(cyc);
    end
    ch_m = (ch_m + 1) % CH;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    ch_m = 0;
    check_val("rst_in_ready", longint'(bus.in_ready), 1);
    check_val("rst_out_valid", longint'(bus.out_valid), 0);
    check_val("rst_busy", longint'(busy), 0);
    check_val("rst_y_zero", longint'(bus.Y != '0), 0);
  endtask

  task automatic send(input logic [16*W-1:0] d, input logic [9*W-1:0] g);
    int t = 0;
    bus.data     = d;
    bus.filter   = g;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      check_val("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    model_accept(d, g);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_out();
    int t = 0;
    int lat;
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.out_valid) begin
      check_val("out_timeout", 0, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      check_val("unexpected_out", 1, 0);
      return;
    end
    last_exp = exp_q.pop_front();
    lat      = lat_q.pop_front();
    check_val("latency", cyc - lat, 3);
    for (int k = 0; k < 4; k++)
      check_val($sformatf("y%0d", k), $signed(bus.Y[k*ACC_W +: ACC_W]),
                $signed(last_exp[k*ACC_W +: ACC_W]));
    $display("out tile @%0d: y00=%0d y01=%0d y10=%0d y11=%0d", cyc,
             $signed(bus.Y[0 +: ACC_W]), $signed(bus.Y[ACC_W +: ACC_W]),
             $signed(bus.Y[2*ACC_W +: ACC_W]), $signed(bus.Y[3*ACC_W +: ACC_W]));
  endtask

  task automatic finish_out(input int stall);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_val("hold_out_valid", longint'(bus.out_valid), 1);
      check_val("hold_in_ready", longint'(bus.in_ready), 0);
      check_val("hold_y_stable", longint'(bus.Y == last_exp), 1);
      check_val("hold_busy", longint'(busy), 1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_val("out_pulse", longint'(bus.out_valid), 0);
    check_val("post_busy", longint'(busy), 0);
    check_val("post_in_ready", longint'(bus.in_ready), 1);
  endtask

  function automatic logic [16*W-1:0] rand_d();
    logic [16*W-1:0] d;
    for (int k = 0; k < 16; k++) d[k*W +: W] = W'($urandom);
    return d;
  endfunction

  function automatic logic [9*W-1:0] rand_g();
    logic [9*W-1:0] g;
    for (int k = 0; k < 9; k++) g[k*W +: W] = W'($urandom);
    return g;
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.data      = '0;
    bus.filter    = '0;
    bus.out_ready = 1'b1;
    ones_d  = {16{8'h01}};
    ones_g  = {9{8'h01}};
    neg_d   = {16{8'h80}};
    pos_g   = {9{8'h7f}};
    delta_g = '0;
    delta_g[4*W +: W] = 8'h01;
    for (int k = 0; k < 16; k++) ramp_d[k*W +: W] = W'(k);
    do_reset();

    // all-ones, back to back: y = 36 everywhere
    send(ones_d, ones_g);
    check_val("busy_after_ch0", longint'(busy), 1);
    repeat (3) send(ones_d, ones_g);
    check_val("drain_in_ready", longint'(bus.in_ready), 0);
    wait_out();
    finish_out(0);

    // extremes: y = -585216
    repeat (4) send(neg_d, pos_g);
    wait_out();
    finish_out(0);

    // ramp with centre delta: y = 20, 24, 36, 40
    repeat (4) send(ramp_d, delta_g);
    wait_out();
    finish_out(0);

    // in_valid toggling across a group
    for (int c = 0; c < 4; c++) begin
      send(ones_d, ones_g);
      if (c < 3) idle(1);
    end
    wait_out();
    finish_out(0);

    // consumer stall with a pair waiting at the input
    bus.out_ready = 1'b0;
    repeat (4) send(rand_d(), rand_g());
    wait_out();
    bus.data     = rand_d();
    bus.filter   = rand_g();
    bus.in_valid = 1'b1;
    finish_out(5);
    for (int c = 0; c < 4; c++) begin
      send(rand_d(), rand_g());
      idle($urandom_range(0, 2));
    end
    wait_out();
    finish_out(0);

    // reset mid-group must leave no residue
    repeat (2) send(ones_d, ones_g);
    do_reset();
    repeat (4) send(ones_d, ones_g);
    wait_out();
    finish_out(0);

    // reset while Y is pending
    bus.out_ready = 1'b0;
    repeat (4) send(rand_d(), rand_g());
    wait_out();
    do_reset();
    bus.out_ready = 1'b1;
    repeat (4) send(ones_d, ones_g);
    wait_out();
    finish_out(0);

    // a few random groups with random gaps
    for (int grp = 0; grp < 3; grp++) begin
      for (int c = 0; c < 4; c++) begin
        send(rand_d(), rand_g());
        idle($urandom_range(0, 1));
      end
      wait_out();
      finish_out(0);
    end

    check_val("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
